cond_unit: RTL and testbench
============================

COND_UNIT -- requirements
Module: cond_unit

Interface
REQ-001 Parameter: none; all widths fixed (cond 4 bits, flag_w 2 bits).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 valid_in  input  1  instruction present at the evaluation stage this cycle.
REQ-005 cond  input  4  instruction condition field (codes 0-15).
REQ-006 flag_w  input  2  bit1 = update N,Z; bit0 = update C,V.
REQ-007 pcs_in, reg_w_in, mem_w_in  input  1 each  ungated branch, register-write and memory-write requests.
REQ-008 Z, N, V, C  input  1 each  ALU flags from the ALU flag mux, same cycle.
REQ-009 stall  input  1  hold all state; no flag update; outputs held.
REQ-010 flush  input  1  kill the current instruction; the output stage is cleared next cycle.
REQ-011 pcs, reg_w, mem_w  output  1 each  gated controls, registered.
REQ-012 valid_out  output  1  registered valid of the gated controls.
REQ-013 flags  output  4  architectural {N,Z,C,V} register.
REQ-014 cond_ex  output  1  combinational condition result against the current flags register.

Function
REQ-015 cond_ex SHALL evaluate cond against registered flags: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; 10 GE N==V; 11 LT N!=V; 12 GT !Z&(N==V); 13 LE Z|(N!=V); 14 AL 1; 15 SHALL evaluate to 0.
REQ-016 The instruction is accepted (acc) when valid_in & !stall & !flush.
REQ-017 On acc & cond_ex, N,Z SHALL load from inputs if flag_w[1], and C,V SHALL load if flag_w[0]; fields whose write bit is 0 SHALL hold.
REQ-018 On acc & !cond_ex, the flags SHALL NOT change.
REQ-019 Output stage, 1-cycle latency: on acc, the next cycle SHALL give valid_out=1 and pcs/reg_w/mem_w = request & cond_ex.
REQ-020 When !stall and (flush or !valid_in), the next cycle SHALL give valid_out, pcs, reg_w and mem_w = 0.
REQ-021 When stall & !flush, all registers SHALL hold their value.
REQ-022 flush SHALL override stall: the output stage is cleared and the flags are not updated.
REQ-023 A flag update from instruction k SHALL be visible to cond_ex of instruction k+1 in the next accepted cycle, with no bypass.

Reset
REQ-024 While rst is high at a clock edge: flags=4'b0000, valid_out=0, pcs=0, reg_w=0 and mem_w=0.
REQ-025 rst SHALL override stall and flush.
REQ-026 An instruction present during the reset cycle SHALL be discarded.
REQ-027 Under COND_TRACE_EN, the trace counter SHALL also reset to 0.

Configuration
REQ-028 Macro COND_TRACE_EN. When defined, the block adds output cond_fail_cnt[15:0].
REQ-029 cond_fail_cnt SHALL increment on each acc & !cond_ex and saturate at 16'hFFFF.
REQ-030 When COND_TRACE_EN is undefined, the port and the counter SHALL be absent, and the remaining behaviour is unchanged.

Structure
REQ-031 Shared package cond_pkg SHALL hold:
- a cond_e enum of the 16 codes (EQ..AL, NV=15);
- the flag-vector bit-index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
REQ-032 One combinational sub-module, cond_check (cond, flags -> cond_ex), is natural; the flag and output registers stay in cond_unit.

Verification
REQ-033 Reset: assert rst with valid_in=1 and cond=AL -> next cycle flags=0000, valid_out=0, all gated outputs 0.
REQ-034 Flag write:
- step 1: cond=AL, flag_w=11, Z=1, N=0, C=1, V=0 -> flags=0110;
- step 2: cond=EQ, pcs_in=1 -> cond_ex=1 and pcs=1 one cycle later.
REQ-035 Failed condition: flags=0110, cond=NE, reg_w_in=1, flag_w=11, inputs N=1 -> reg_w=0, valid_out=1, flags stay 0110.
REQ-036 Partial write: flags=0000, cond=AL, flag_w=01, N=1, Z=1, C=1, V=1 -> flags=0011.
REQ-037 Signed conditions: for each of flags=1001 and 1000, sweep GE/LT/GT/LE/HI/LS and code 15 -> cond_ex matches the REQ-015 table; code 15 gives 0.
REQ-038 Stall and flush:
- stall=1 for 3 cycles with flag_w=11 -> flags and outputs unchanged;
- stall=1 and flush=1 together -> next cycle valid_out=0 and flags unchanged;
- under COND_TRACE_EN, 3 accepted failing instructions -> cond_fail_cnt=3.

Source files
------------

// File: rtl/cond_pkg.sv
// cond_pkg: condition codes and flag-vector bit positions shared by the condition unit
package cond_pkg;
    typedef enum logic [3:0] {EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL, NV} cond_e;
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;
endpackage

// File: rtl/cond_if.sv
// cond_if: evaluation-stage bus of the condition unit; COND_TRACE_EN adds cond_fail_cnt
interface cond_if;
    logic       valid_in;
    logic [3:0] cond;
    logic [1:0] flag_w;
    logic       pcs_in;
    logic       reg_w_in;
    logic       mem_w_in;
    logic       Z;
    logic       N;
    logic       V;
    logic       C;
    logic       stall;
    logic       flush;
    logic       pcs;
    logic       reg_w;
    logic       mem_w;
    logic       valid_out;
    logic [3:0] flags;
    logic       cond_ex;
`ifdef COND_TRACE_EN
    logic [15:0] cond_fail_cnt;
    modport master (output valid_in, cond, flag_w, pcs_in, reg_w_in, mem_w_in, Z, N, V, C, stall, flush,
                    input pcs, reg_w, mem_w, valid_out, flags, cond_ex, cond_fail_cnt);
    modport slave (input valid_in, cond, flag_w, pcs_in, reg_w_in, mem_w_in, Z, N, V, C, stall, flush,
                   output pcs, reg_w, mem_w, valid_out, flags, cond_ex, cond_fail_cnt);
`else
    modport master (output valid_in, cond, flag_w, pcs_in, reg_w_in, mem_w_in, Z, N, V, C, stall, flush,
                    input pcs, reg_w, mem_w, valid_out, flags, cond_ex);
    modport slave (input valid_in, cond, flag_w, pcs_in, reg_w_in, mem_w_in, Z, N, V, C, stall, flush,
                   output pcs, reg_w, mem_w, valid_out, flags, cond_ex);
`endif
endinterface

// File: rtl/cond_check.sv
// cond_check: combinational evaluation of a condition code against the flag register
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] flags_i,
    output logic       cond_ex_o
);
    logic n, z, c, v;
    assign n = flags_i[FLAG_N];
    assign z = flags_i[FLAG_Z];
    assign c = flags_i[FLAG_C];
    assign v = flags_i[FLAG_V];
    // decode the condition code; NV is never taken
    always_comb begin
        cond_ex_o = 1'b0;
        case (cond_e'(cond_i))
            EQ: cond_ex_o = z;
            NE: cond_ex_o = !z;
            CS: cond_ex_o = c;
            CC: cond_ex_o = !c;
            MI: cond_ex_o = n;
            PL: cond_ex_o = !n;
            VS: cond_ex_o = v;
            VC: cond_ex_o = !v;
            HI: cond_ex_o = c && !z;
            LS: cond_ex_o = !c || z;
            GE: cond_ex_o = n == v;
            LT: cond_ex_o = n != v;
            GT: cond_ex_o = !z && (n == v);
            LE: cond_ex_o = z || (n != v);
            AL: cond_ex_o = 1'b1;
            NV: cond_ex_o = 1'b0;
        endcase
    end
endmodule

// File: rtl/cond_unit.sv
// cond_unit: flag register, condition gating and registered control outputs; COND_TRACE_EN adds a failed-condition counter
module cond_unit
    import cond_pkg::*;
(
    input logic clk,
    input logic rst,
    cond_if.slave bus
);
    logic [3:0] flags_q, flags_d;
    logic       valid_q, pcs_q, reg_w_q, mem_w_q;
    logic       cond_ex, acc;

    cond_check u_check (.cond_i(bus.cond), .flags_i(flags_q), .cond_ex_o(cond_ex));

    assign acc = bus.valid_in && !bus.stall && !bus.flush;

    // flags load only from an accepted, executed instruction, per write-enable half
    always_comb begin
        flags_d = flags_q;
        if (acc && cond_ex && bus.flag_w[1]) begin
            flags_d[FLAG_N] = bus.N;
            flags_d[FLAG_Z] = bus.Z;
        end
        if (acc && cond_ex && bus.flag_w[0]) begin
            flags_d[FLAG_C] = bus.C;
            flags_d[FLAG_V] = bus.V;
        end
    end

    // output stage and flags advance unless stalled; flush clears the stage even under stall
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= 4'b0000;
            valid_q <= 1'b0;
            pcs_q   <= 1'b0;
            reg_w_q <= 1'b0;
            mem_w_q <= 1'b0;
        end else if (bus.flush || !bus.stall) begin
            flags_q <= flags_d;
            valid_q <= acc;
            pcs_q   <= acc && cond_ex && bus.pcs_in;
            reg_w_q <= acc && cond_ex && bus.reg_w_in;
            mem_w_q <= acc && cond_ex && bus.mem_w_in;
        end
    end

`ifdef COND_TRACE_EN
    logic [15:0] cnt_q;
    // count accepted instructions whose condition failed, saturating
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= 16'h0000;
        else if (acc && !cond_ex && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'h0001;
    end
    assign bus.cond_fail_cnt = cnt_q;
`endif

    assign bus.flags     = flags_q;
    assign bus.valid_out = valid_q;
    assign bus.pcs       = pcs_q;
    assign bus.reg_w     = reg_w_q;
    assign bus.mem_w     = mem_w_q;
    assign bus.cond_ex   = cond_ex;
endmodule

// File: tb/tb_cond_unit.sv
// tb_cond_unit: scoreboard bench for cond_unit with a behavioural flag/condition model
module tb_cond_unit;
    import cond_pkg::*;

    typedef struct {
        logic [3:0]  f;
        logic [3:0]  o;
        logic [15:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    cond_if bus ();
    cond_unit dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    exp_t q[$];
    exp_t e;
    logic [3:0]  mf = 4'b0000;
    logic [3:0]  mo = 4'b0000;
    logic [15:0] mcnt = 16'h0000;
    logic        known = 1'b0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // table of the spec's conditions, grouped as positive/negated pairs
    function automatic logic ref_cond(input logic [3:0] cd, input logic [3:0] f);
        logic n, z, c, v;
        logic [7:0] base;
        logic [2:0] idx;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        base = {1'b1, !z && (n == v), n == v, c && !z, v, n, c, z};
        idx = cd[3:1];
        if (cd == 4'd15) return 1'b0;
        return base[idx] ^ cd[0];
    endfunction

    task automatic step(input logic r, input logic vi, input logic [3:0] cd, input logic [1:0] fw,
                        input logic p, input logic rw, input logic mw,
                        input logic n, input logic z, input logic c, input logic v,
                        input logic st, input logic fl);
        logic ce, acc;
        exp_t x;
        @(negedge clk);
        rst = r; bus.valid_in = vi; bus.cond = cd; bus.flag_w = fw;
        bus.pcs_in = p; bus.reg_w_in = rw; bus.mem_w_in = mw;
        bus.N = n; bus.Z = z; bus.C = c; bus.V = v; bus.stall = st; bus.flush = fl;
        #1;
        ce = ref_cond(cd, mf);
        if (known) chk("cond_ex", {15'd0, bus.cond_ex}, {15'd0, ce});
        acc = vi && !st && !fl;
        if (r) begin
            mf = 4'b0000; mo = 4'b0000; mcnt = 16'h0000; known = 1'b1;
        end else if (fl || !st) begin
            mo = {acc, acc && ce && p, acc && ce && rw, acc && ce && mw};
            if (acc && ce && fw[1]) begin mf[3] = n; mf[2] = z; end
            if (acc && ce && fw[0]) begin mf[1] = c; mf[0] = v; end
            if (acc && !ce && mcnt != 16'hFFFF) mcnt = mcnt + 16'h0001;
        end
        x.f = mf; x.o = mo; x.cnt = mcnt;
        q.push_back(x);
    endtask

    // monitor: each clock the DUT presents a new output stage; compare with the oldest expectation
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("flags", {12'd0, bus.flags}, {12'd0, e.f});
            chk("outs{valid,pcs,reg_w,mem_w}", {12'd0, bus.valid_out, bus.pcs, bus.reg_w, bus.mem_w}, {12'd0, e.o});
`ifdef COND_TRACE_EN
            chk("cond_fail_cnt", bus.cond_fail_cnt, e.cnt);
`endif
        end
    end

    initial begin
        bus.valid_in = 0; bus.cond = 0; bus.flag_w = 0; bus.pcs_in = 0; bus.reg_w_in = 0; bus.mem_w_in = 0;
        bus.N = 0; bus.Z = 0; bus.C = 0; bus.V = 0; bus.stall = 0; bus.flush = 0;
        // reset with a live AL instruction that must be discarded
        step(1, 1, AL, 2'b11, 1, 1, 1, 1, 1, 1, 1, 0, 0);
        // flag write then EQ taken
        step(0, 1, AL, 2'b11, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        step(0, 1, EQ, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        // failing NE must not write flags nor reg_w
        step(0, 1, NE, 2'b11, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        // partial write of C,V only
        step(1, 0, AL, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, AL, 2'b01, 0, 0, 0, 1, 1, 1, 1, 0, 0);
        // signed/unsigned sweeps for flags 1001 and 1000
        step(0, 1, AL, 2'b11, 0, 0, 0, 1, 0, 0, 1, 0, 0);
        for (int k = 8; k < 16; k++) step(0, 1, 4'(k), 2'b00, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, AL, 2'b11, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        for (int k = 8; k < 16; k++) step(0, 1, 4'(k), 2'b00, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        // stall holds everything, flush beats stall
        step(0, 1, AL, 2'b11, 1, 1, 1, 0, 1, 1, 0, 0, 0);
        for (int k = 0; k < 3; k++) step(0, 1, AL, 2'b11, 0, 0, 0, 1, 0, 0, 1, 1, 0);
        step(0, 1, AL, 2'b11, 1, 1, 1, 1, 0, 0, 1, 1, 1);
        // three accepted failing instructions after reset
        step(1, 0, AL, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) step(0, 1, NV, 2'b11, 1, 1, 1, 1, 1, 1, 1, 0, 0);
        // random traffic
        for (int k = 0; k < 400; k++)
            step($urandom_range(0, 31) == 0, 1'($urandom), 4'($urandom), 2'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 16'(q.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
